// File: rtl/sw_io_defs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sw_io_defs : shared CPU bus address map and mem_cmd encodings        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package sw_io_defs;

    localparam logic [8:0] SW_STATE_ADDR = 9'h140;
    localparam logic [8:0] SW_EDGE_ADDR  = 9'h141;
    localparam logic [8:0] SW_CTRL_ADDR  = 9'h142;

    typedef enum logic [1:0] {
        MNONE  = 2'b00,
        MREAD  = 2'b01,
        MWRITE = 2'b10
    } mem_cmd_e;

    function automatic logic is_sw_port_addr(input logic [8:0] addr);
        return (addr == SW_STATE_ADDR) || (addr == SW_EDGE_ADDR) || (addr == SW_CTRL_ADDR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sw_debounce_bit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sw_debounce_bit : 2-FF synchroniser, tick-sampled history, stable FF |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sw_debounce_bit #(
    parameter int STABLE_SAMPLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic sw,
    output logic stable,
    output logic rise,
    output logic fall
);

    logic                      sync1;
    logic                      sync2;
    logic [STABLE_SAMPLES-1:0] samples;
    logic [STABLE_SAMPLES-1:0] shifted;
    logic                      all_ones;
    logic                      all_zeros;

    // Acceptance looks at the history including the sample taken on this tick.
    assign shifted   = {samples[STABLE_SAMPLES-2:0], sync2};
    assign all_ones  = &shifted;
    assign all_zeros = ~|shifted;
    assign rise      = tick & all_ones & ~stable;
    assign fall      = tick & all_zeros & stable;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            samples <= '0;
            stable  <= 1'b0;
        end else begin
            sync1 <= sw;
            sync2 <= sync1;
            if (tick) begin
                samples <= shifted;
            end
            if (rise) begin
                stable <= 1'b1;
            end else if (fall) begin
                stable <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sw_input_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sw_input_port : debounced switch peripheral with sticky edge capture |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sw_input_port
    import sw_io_defs::*;
#(
    parameter int WIDTH          = 8,
    parameter int TICK_DIV       = 50000,
    parameter int STABLE_SAMPLES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw,
    input  logic [8:0]       mem_addr,
    input  logic [1:0]       mem_cmd,
    input  logic [15:0]      wdata,
    output logic [15:0]      rdata,
    output logic             rd_en,
    output logic             irq
);

    localparam int CNT_W = $clog2(TICK_DIV);

    logic [CNT_W-1:0] prescale;
    logic             tick;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_bits;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] edge_next;
    logic [1:0]       ctrl;
    logic             is_read;
    logic             is_write;
    logic             hit_state;
    logic             hit_edge;
    logic             hit_ctrl;
    logic             unused_wdata;

    assign tick = (prescale == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescale <= '0;
        end else if (tick) begin
            prescale <= '0;
        end else begin
            prescale <= prescale + 1'b1;
        end
    end

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            sw_debounce_bit #(
                .STABLE_SAMPLES(STABLE_SAMPLES)
            ) u_debounce (
                .clk    (clk),
                .reset_n(reset_n),
                .tick   (tick),
                .sw     (sw[i]),
                .stable (stable[i]),
                .rise   (rise[i]),
                .fall   (fall[i])
            );
        end
    endgenerate

    assign is_read   = (mem_cmd == MREAD);
    assign is_write  = (mem_cmd == MWRITE);
    assign hit_state = (mem_addr == SW_STATE_ADDR);
    assign hit_edge  = (mem_addr == SW_EDGE_ADDR);
    assign hit_ctrl  = (mem_addr == SW_CTRL_ADDR);

    // Set has priority over a same-cycle write-1-to-clear of the same bit.
    assign edge_set  = (rise & {WIDTH{ctrl[0]}}) | (fall & {WIDTH{ctrl[1]}});
    assign edge_clr  = (is_write && hit_edge) ? wdata[WIDTH-1:0] : '0;
    assign edge_next = (edge_bits & ~edge_clr) | edge_set;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_bits <= '0;
            ctrl      <= 2'b01;
            irq       <= 1'b0;
        end else begin
            edge_bits <= edge_next;
            irq       <= |edge_next;
            if (is_write && hit_ctrl) begin
                ctrl <= wdata[1:0];
            end
        end
    end

    always_comb begin
        rdata = '0;
        rd_en = is_read && is_sw_port_addr(mem_addr);
        if (rd_en) begin
            if (hit_state) begin
                rdata[WIDTH-1:0] = stable;
            end else if (hit_edge) begin
                rdata[WIDTH-1:0] = edge_bits;
            end else begin
                rdata[1:0] = ctrl;
            end
        end
    end

    assign unused_wdata = ^wdata[15:WIDTH];

endmodule
`default_nettype wire

// File: tb/tb_sw_input_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sw_input_port : vector table, directed corners, random vs model   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_sw_input_port;
    import sw_io_defs::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  sw = 8'h00;
    logic [8:0]  mem_addr = 9'h000;
    logic [1:0]  mem_cmd = MNONE;
    logic [15:0] wdata = 16'h0000;
    logic [15:0] rdata;
    logic        rd_en;
    logic        irq;

    int checks = 0;
    int errors = 0;

    sw_input_port #(
        .WIDTH(8),
        .TICK_DIV(4),
        .STABLE_SAMPLES(4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sw      (sw),
        .mem_addr(mem_addr),
        .mem_cmd (mem_cmd),
        .wdata   (wdata),
        .rdata   (rdata),
        .rd_en   (rd_en),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    // Reference model: history of switch values seen at each clock edge,
    // the list of tick samples, and the architectural registers.
    int         n;
    logic [7:0] hist[$];
    logic [7:0] samp[$];
    logic [7:0] m_stable;
    logic [7:0] m_edge;
    logic [1:0] m_ctrl;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        n = 0;
        hist.delete();
        samp.delete();
        repeat (4) samp.push_back(8'h00);
        m_stable = 8'h00;
        m_edge   = 8'h00;
        m_ctrl   = 2'b01;
    endtask

    task automatic model_calc(input logic [8:0] a, input logic [1:0] c, input logic [15:0] wd,
                              output logic [7:0] ns, output logic [7:0] ne, output logic [1:0] nc,
                              output logic [7:0] set_v, output logic tk, output logic [7:0] sv);
        int         nn;
        logic [7:0] ones, zeros, rise, fall, clr;
        nn    = n + 1;
        tk    = (nn % 4 == 0);
        sv    = (nn >= 3) ? hist[nn - 3] : 8'h00;
        ns    = m_stable;
        if (tk) begin
            ones  = samp[samp.size()-3] & samp[samp.size()-2] & samp[samp.size()-1] & sv;
            zeros = ~(samp[samp.size()-3] | samp[samp.size()-2] | samp[samp.size()-1] | sv);
            ns    = (m_stable | ones) & ~zeros;
        end
        rise  = ns & ~m_stable;
        fall  = ~ns & m_stable;
        set_v = (rise & {8{m_ctrl[0]}}) | (fall & {8{m_ctrl[1]}});
        clr   = (c == MWRITE && a == SW_EDGE_ADDR) ? wd[7:0] : 8'h00;
        ne    = (m_edge & ~clr) | set_v;
        nc    = (c == MWRITE && a == SW_CTRL_ADDR) ? wd[1:0] : m_ctrl;
    endtask

    function automatic logic [15:0] m_rdata(input logic [8:0] a, input logic [1:0] c);
        if (c != MREAD) return 16'h0000;
        case (a)
            SW_STATE_ADDR: return {8'h00, m_stable};
            SW_EDGE_ADDR:  return {8'h00, m_edge};
            SW_CTRL_ADDR:  return {14'h0, m_ctrl};
            default:       return 16'h0000;
        endcase
    endfunction

    // One clock cycle: drive bus, compare outputs with model, advance both.
    task automatic step(input logic [8:0] a, input logic [1:0] c, input logic [15:0] wd);
        logic [7:0] ns, ne, set_v, sv;
        logic [1:0] nc;
        logic       tk;
        logic       exp_rd;
        mem_addr = a;
        mem_cmd  = c;
        wdata    = wd;
        #2;
        exp_rd = (c == MREAD) && (a == SW_STATE_ADDR || a == SW_EDGE_ADDR || a == SW_CTRL_ADDR);
        check("model_rd_en", {31'b0, rd_en}, {31'b0, exp_rd});
        check("model_rdata", {16'b0, rdata}, {16'b0, m_rdata(a, c)});
        check("model_irq", {31'b0, irq}, {31'b0, |m_edge});
        model_calc(a, c, wd, ns, ne, nc, set_v, tk, sv);
        @(posedge clk);
        hist.push_back(sw);
        if (tk) samp.push_back(sv);
        m_stable = ns;
        m_edge   = ne;
        m_ctrl   = nc;
        n++;
        #1;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(9'h000, MNONE, 16'h0000);
    endtask

    task automatic chk_read(input logic [8:0] a, input logic [15:0] exp, input string name);
        mem_addr = a;
        mem_cmd  = MREAD;
        #1;
        check({name, "_rd_en"}, {31'b0, rd_en}, 32'd1);
        check(name, {16'b0, rdata}, {16'b0, exp});
        step(a, MREAD, 16'h0000);
    endtask

    typedef struct {
        logic [8:0]  addr;
        logic [1:0]  cmd;
        logic [15:0] wdata;
        logic        exp_rd_en;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [7:0] ns, ne, set_v, sv;
        logic [1:0] nc;
        logic       tk;
        logic       found;
        logic [8:0] raddrs[5];

        vecs[0]  = '{9'h140, MREAD,  16'h0000, 1'b1, 16'h0000};
        vecs[1]  = '{9'h141, MREAD,  16'h0000, 1'b1, 16'h0000};
        vecs[2]  = '{9'h142, MREAD,  16'h0000, 1'b1, 16'h0001};
        vecs[3]  = '{9'h100, MREAD,  16'h0000, 1'b0, 16'h0000};
        vecs[4]  = '{9'h143, MREAD,  16'h0000, 1'b0, 16'h0000};
        vecs[5]  = '{9'h14F, MREAD,  16'h0000, 1'b0, 16'h0000};
        vecs[6]  = '{9'h140, MWRITE, 16'hFFFF, 1'b0, 16'h0000};
        vecs[7]  = '{9'h140, MREAD,  16'h0000, 1'b1, 16'h0000};
        vecs[8]  = '{9'h142, MWRITE, 16'hFFFF, 1'b0, 16'h0000};
        vecs[9]  = '{9'h142, MREAD,  16'h0000, 1'b1, 16'h0003};
        vecs[10] = '{9'h143, MWRITE, 16'h0000, 1'b0, 16'h0000};
        vecs[11] = '{9'h142, MREAD,  16'h0000, 1'b1, 16'h0003};

        // Reset and table-driven register map checks
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("reset_irq", {31'b0, irq}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            mem_addr = vecs[i].addr;
            mem_cmd  = vecs[i].cmd;
            wdata    = vecs[i].wdata;
            #1;
            check($sformatf("vec%0d_rd_en", i), {31'b0, rd_en}, {31'b0, vecs[i].exp_rd_en});
            check($sformatf("vec%0d_rdata", i), {16'b0, rdata}, {16'b0, vecs[i].exp_rdata});
            step(vecs[i].addr, vecs[i].cmd, vecs[i].wdata);
        end
        step(9'h142, MWRITE, 16'h0001);
        chk_read(9'h142, 16'h0001, "ctrl_restored");

        // Debounce and rising edge capture
        sw = 8'h05;
        idle(18);
        chk_read(9'h140, 16'h0005, "rise_state");
        chk_read(9'h141, 16'h0005, "rise_edge");
        check("rise_irq", {31'b0, irq}, 32'd1);
        step(9'h141, MWRITE, 16'h0001);
        chk_read(9'h141, 16'h0004, "w1c_bit0");
        check("w1c_bit0_irq", {31'b0, irq}, 32'd1);
        step(9'h141, MWRITE, 16'h0004);
        chk_read(9'h141, 16'h0000, "w1c_bit2");
        check("w1c_irq_low", {31'b0, irq}, 32'd0);

        // Glitch rejection: short pulse, then a long pulse with sampled gaps
        sw = 8'h0D;
        idle(3);
        sw = 8'h05;
        idle(20);
        chk_read(9'h140, 16'h0005, "glitch_state");
        chk_read(9'h141, 16'h0000, "glitch_edge");
        for (int i = 0; i < 12; i++) begin
            sw = (((n + 1) % 4 == 2) && i >= 4 && i < 8) ? 8'h05 : 8'h0D;
            idle(1);
        end
        sw = 8'h05;
        idle(20);
        chk_read(9'h140, 16'h0005, "gap_state");
        chk_read(9'h141, 16'h0000, "gap_edge");

        // Falling edge capture only
        step(9'h142, MWRITE, 16'h0002);
        sw = 8'h00;
        idle(20);
        chk_read(9'h140, 16'h0000, "fall_state");
        chk_read(9'h141, 16'h0005, "fall_edge");
        step(9'h141, MWRITE, 16'h0005);
        sw = 8'h05;
        idle(20);
        chk_read(9'h140, 16'h0005, "fall_only_state");
        chk_read(9'h141, 16'h0000, "fall_only_edge");
        check("fall_only_irq", {31'b0, irq}, 32'd0);

        // Set and clear of EDGE[1] on the same edge
        step(9'h142, MWRITE, 16'h0001);
        sw = 8'h07;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            model_calc(9'h000, MNONE, 16'h0000, ns, ne, nc, set_v, tk, sv);
            if (set_v[1]) begin
                step(9'h141, MWRITE, 16'h0002);
                found = 1'b1;
            end else begin
                idle(1);
            end
        end
        check("collision_found", {31'b0, found}, 32'd1);
        chk_read(9'h141, 16'h0002, "collision_edge");

        // All EDGE bits set, then asynchronous reset mid-debounce
        step(9'h142, MWRITE, 16'h0003);
        sw = 8'hFA;
        idle(20);
        chk_read(9'h141, 16'h00FF, "all_edge");
        check("all_edge_irq", {31'b0, irq}, 32'd1);
        sw = 8'h00;
        idle(6);
        #2;
        reset_n = 1'b0;
        mem_cmd = MREAD;
        mem_addr = 9'h140; #1;
        check("areset_state", {16'b0, rdata}, 32'h0000);
        mem_addr = 9'h141; #1;
        check("areset_edge", {16'b0, rdata}, 32'h0000);
        mem_addr = 9'h142; #1;
        check("areset_ctrl", {16'b0, rdata}, 32'h0001);
        check("areset_irq", {31'b0, irq}, 32'd0);
        mem_cmd = MNONE;
        model_reset();
        sw = 8'h81;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(18);
        chk_read(9'h140, 16'h0081, "reacq_state");
        chk_read(9'h141, 16'h0081, "reacq_edge");

        // Randomised traffic checked every cycle against the model
        raddrs[0] = 9'h140; raddrs[1] = 9'h141; raddrs[2] = 9'h142;
        raddrs[3] = 9'h143; raddrs[4] = 9'h100;
        for (int i = 0; i < 1500; i++) begin
            int r;
            if ($urandom_range(0, 11) == 0) sw = 8'($urandom);
            else if ($urandom_range(0, 15) == 0) sw = sw ^ (8'h01 << $urandom_range(0, 7));
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3: step(raddrs[$urandom_range(0, 4)], MREAD, 16'h0000);
                4:          step(9'h141, MWRITE, 16'($urandom));
                5:          step(9'h142, MWRITE, 16'($urandom));
                6:          step($urandom_range(0, 1) ? 9'h140 : 9'h143, MWRITE, 16'($urandom));
                default:    step(9'h000, MNONE, 16'h0000);
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
